// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and default constants for the UART TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default sizing for the arbiter
    localparam int NREQ_DEF    = 4;
    localparam int WIDTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 255;

    // Arbiter state: either no owner, or one requester owns the FIFO
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational round-robin picker. Searches ptr+1, ptr+2, ...
//               modulo NREQ and returns the first asserted request.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] pick,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int cand;

    // Walk the requesters in priority order starting just after ptr
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any        = 1'b1;
                idx        = IDXW'(cand);
                pick[cand] = 1'b1;
            end
        end
    end

endmodule : uart_rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter granting whole messages from NREQ byte
//               requesters into a shared UART TX FIFO, with an idle timeout
//               that revokes a stalled grant.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_wr,
    output logic [WIDTH-1:0]      fifo_data,
    input  logic                  fifo_full,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  timeout_err
);

    localparam int              IDXW   = $clog2(NREQ);
    localparam int              CNTW   = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] TO_VAL = CNTW'(TIMEOUT);

    arb_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] idle_cnt_q, idle_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    logic [NREQ-1:0] pick_onehot;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            owner_valid;
    logic            owner_last;
    logic [CNTW-1:0] idle_inc;

    uart_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req  (req_valid),
        .ptr  (ptr_q),
        .pick (pick_onehot),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Current owner's handshake view and the saturating idle increment
    always_comb begin
        owner_valid = req_valid[idx_q];
        owner_last  = req_last[idx_q];
        fifo_data   = req_data[idx_q*WIDTH +: WIDTH];
        idle_inc    = (idle_cnt_q == TO_VAL) ? idle_cnt_q : idle_cnt_q + 1'b1;
    end

    // Byte path: only the owner sees ready, and only while BUSY
    always_comb begin
        req_ready = '0;
        fifo_wr   = 1'b0;
        if (state_q == ST_BUSY) begin
            req_ready = grant_q & {NREQ{~fifo_full}};
            fifo_wr   = owner_valid & ~fifo_full;
        end
    end

    // Next-state: arbitrate in IDLE, release on last byte or idle timeout
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        idx_d         = idx_q;
        ptr_d         = ptr_q;
        idle_cnt_d    = idle_cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idle_cnt_d = '0;
                if (pick_any) begin
                    state_d = ST_BUSY;
                    grant_d = pick_onehot;
                    idx_d   = pick_idx;
                end
            end
            ST_BUSY: begin
                if (fifo_wr && owner_last) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    ptr_d      = idx_q;
                    idle_cnt_d = '0;
                end else if (!owner_valid) begin
                    // A full FIFO with valid data is backpressure, not idleness
                    idle_cnt_d = idle_inc;
                    if (idle_inc == TO_VAL) begin
                        state_d       = ST_IDLE;
                        grant_d       = '0;
                        ptr_d         = idx_q;
                        idle_cnt_d    = '0;
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; reset leaves requester 0 first in line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            idx_q         <= '0;
            ptr_q         <= IDXW'(NREQ - 1);
            idle_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            idx_q         <= idx_d;
            ptr_q         <= ptr_d;
            idle_cnt_q    <= idle_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant       = grant_q;
    assign busy        = (state_q == ST_BUSY);
    assign timeout_err = timeout_err_q;

endmodule : uart_tx_arbiter
`default_nettype wire
